// File: rtl/demux_1to4_deser_pkg.sv
// Shared types and helpers for the 1-to-4 lane deserializer.
// Holds the FSM state encoding, default geometry and the lane slicing helper.
package demux_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        STALL   = 2'd2
    } state_t;

    localparam int LANES_DEF  = 4;
    localparam int LANE_W_DEF = 1;

    function automatic int lane_offset(input int index, input int lane_w);
        return index * lane_w;
    endfunction

endpackage

// File: rtl/demux_1to4_deser_if.sv
// Beat-side and frame-side handshake bundle of the lane deserializer.
// master is the link/consumer side; slave is the deserializer itself.
interface demux_1to4_deser_if
    import demux_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int LANE_W = LANE_W_DEF
);
    localparam int SEL_W = $clog2(LANES);

    logic [LANE_W-1:0]       data_in;
    logic [SEL_W-1:0]        sel_n;
    logic                    frame_start;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*LANE_W-1:0] data_out;
    logic                    out_valid;
    logic                    out_ready;
    logic                    err_seq;

    modport master (
        output data_in, sel_n, frame_start, in_valid, out_ready,
        input  in_ready, data_out, out_valid, err_seq
    );

    modport slave (
        input  data_in, sel_n, frame_start, in_valid, out_ready,
        output in_ready, data_out, out_valid, err_seq
    );

endinterface

// File: rtl/demux_1to4_deser_out_reg.sv
// Output register of the deserializer: loads a completed frame and holds it
// stable until the consumer takes it.
module demux_out_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic [W-1:0] data_out,
    output logic         out_valid,
    output logic         can_load
);

    // A new frame may enter when the slot is empty or being drained this edge.
    assign can_load = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            data_out  <= load_data;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1to4_deser.sv
// Routes lane-tagged serial beats into lane slots and presents each completed
// frame as one parallel word; protocol violations raise a one-cycle err_seq.
module demux_1to4_deser
    import demux_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int LANE_W = LANE_W_DEF
) (
    input logic               clk,
    input logic               rst_n,
    demux_1to4_deser_if.slave bus
);

    localparam int SEL_W = $clog2(LANES);
    localparam int W     = LANES * LANE_W;
    localparam logic [SEL_W-1:0] LAST = SEL_W'(LANES - 1);

    state_t           state, state_next;
    logic [SEL_W-1:0] exp_q, exp_next;
    logic [W-1:0]     asm_q, asm_next, asm_wr;
    logic             err_q, err_next;
    logic             accept, load, can_load;
    logic [W-1:0]     load_data;

    assign bus.in_ready = (state != STALL) && rst_n;
    assign bus.err_seq  = err_q;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        asm_wr = asm_q;
        asm_wr[lane_offset(int'(bus.sel_n), LANE_W) +: LANE_W] = bus.data_in;
    end

    // In STALL the completed frame already sits in asm; otherwise it is built this cycle.
    assign load_data = (state == STALL) ? asm_q : asm_wr;

    always_comb begin
        state_next = state;
        exp_next   = exp_q;
        asm_next   = asm_q;
        err_next   = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.frame_start && bus.sel_n == '0) begin
                        asm_next   = asm_wr;
                        exp_next   = SEL_W'(1);
                        state_next = COLLECT;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (!bus.frame_start && bus.sel_n == exp_q) begin
                        asm_next = asm_wr;
                        if (bus.sel_n == LAST) begin
                            exp_next = '0;
                            if (can_load) begin
                                load       = 1'b1;
                                state_next = IDLE;
                            end else begin
                                state_next = STALL;
                            end
                        end else begin
                            exp_next = exp_q + SEL_W'(1);
                        end
                    end else if (bus.frame_start && bus.sel_n == '0) begin
                        err_next = 1'b1;
                        asm_next = asm_wr;
                        exp_next = SEL_W'(1);
                    end else begin
                        err_next   = 1'b1;
                        exp_next   = '0;
                        state_next = IDLE;
                    end
                end
            end
            STALL: begin
                if (bus.out_ready) begin
                    load       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            exp_q <= '0;
            asm_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            exp_q <= exp_next;
            asm_q <= asm_next;
            err_q <= err_next;
        end
    end

    demux_out_reg #(.W(W)) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .out_ready (bus.out_ready),
        .data_out  (bus.data_out),
        .out_valid (bus.out_valid),
        .can_load  (can_load)
    );

endmodule

// File: tb/tb_demux_1to4_deser.sv
// Scoreboard bench for demux_1to4_deser: a frame-level model predicts
// completed words and error pulses; a negedge monitor checks every transfer.
module tb_demux_1to4_deser;
    import demux_pkg::*;

    localparam int LANES  = 4;
    localparam int LANE_W = 1;
    localparam int SEL_W  = $clog2(LANES);
    localparam int W      = LANES * LANE_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    demux_1to4_deser_if #(.LANES(LANES), .LANE_W(LANE_W)) bus ();

    demux_1to4_deser #(.LANES(LANES), .LANE_W(LANE_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int           compared   = 0;
    int           mismatched = 0;
    logic [W-1:0] sb[$];
    int           partial_len  = 0;
    logic [W-1:0] partial_word = '0;
    logic         err_exp      = 1'b0;
    int           ready_mode   = 1;
    int           gen_idx      = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Frame-level reference: a frame is lanes 0..LANES-1 in order, opened by frame_start.
    task automatic modelBeat(input logic fs, input logic [SEL_W-1:0] sel, input logic [LANE_W-1:0] d);
        if (fs && sel == 0) begin
            if (partial_len > 0) err_exp = 1'b1;
            partial_word = '0;
            partial_word[0 +: LANE_W] = d;
            partial_len = 1;
        end else if (partial_len > 0 && !fs && int'(sel) == partial_len) begin
            partial_word[int'(sel) * LANE_W +: LANE_W] = d;
            partial_len++;
            if (partial_len == LANES) begin
                sb.push_back(partial_word);
                partial_len = 0;
            end
        end else begin
            err_exp = 1'b1;
            partial_len = 0;
        end
    endtask

    function automatic logic pickReady();
        if (ready_mode == 2) return 1'($urandom_range(0, 1));
        return ready_mode == 1;
    endfunction

    task automatic applyStimulus(input logic vld, input logic fs, input logic [SEL_W-1:0] sel,
                                 input logic [LANE_W-1:0] d, output logic accepted);
        @(posedge clk);
        #1;
        rst_n           = 1'b1;
        bus.in_valid    = vld;
        bus.frame_start = fs;
        bus.sel_n       = sel;
        bus.data_in     = d;
        bus.out_ready   = pickReady();
        #3;
        checkOutput("err_seq", bus.err_seq, err_exp);
        err_exp = 1'b0;
        checkOutput("in_ready", bus.in_ready, sb.size() < 2);
        accepted = vld && bus.in_ready;
        if (accepted) modelBeat(fs, sel, d);
    endtask

    task automatic sendBeat(input logic fs, input logic [SEL_W-1:0] sel, input logic [LANE_W-1:0] d);
        logic acc;
        int   tries;
        tries = 0;
        do begin
            applyStimulus(1'b1, fs, sel, d, acc);
            tries++;
        end while (!acc && tries < 64);
        if (!acc) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL accept_timeout: beat sel=%0d not accepted in %0d cycles", sel, tries);
        end
    endtask

    task automatic sendFrame(input logic [W-1:0] word);
        for (int i = 0; i < LANES; i++)
            sendBeat(i == 0, SEL_W'(i), word[i * LANE_W +: LANE_W]);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, '0, '0, acc);
    endtask

    task automatic resetDut(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst_n           = 1'b0;
            bus.in_valid    = 1'b1;
            bus.frame_start = 1'($urandom_range(0, 1));
            bus.sel_n       = SEL_W'($urandom_range(0, LANES - 1));
            bus.data_in     = LANE_W'($urandom);
            bus.out_ready   = 1'b0;
            #3;
            checkOutput("rst_in_ready", bus.in_ready, 1'b0);
            if (i > 0) begin
                checkOutput("rst_data_out", bus.data_out, '0);
                checkOutput("rst_out_valid", bus.out_valid, 1'b0);
                checkOutput("rst_err_seq", bus.err_seq, 1'b0);
            end
        end
        sb.delete();
        partial_len = 0;
        err_exp     = 1'b0;
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        #3;
        checkOutput("rel_in_ready", bus.in_ready, 1'b1);
        checkOutput("rel_out_valid", bus.out_valid, 1'b0);
    endtask

    // Monitor: every out_valid&&out_ready transfer must match the oldest predicted frame.
    logic [W-1:0] held_data;
    bit           held = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            held = 0;
        end else begin
            if (held) begin
                checkOutput("out_valid_hold", bus.out_valid, 1'b1);
                checkOutput("data_out_stable", bus.data_out, held_data);
            end
            held = 0;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_frame: got %0h with empty scoreboard", bus.data_out);
                end else begin
                    checkOutput("frame", bus.data_out, sb.pop_front());
                end
            end else if (bus.out_valid) begin
                held      = 1;
                held_data = bus.data_out;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r;
        bus.in_valid    = 1'b0;
        bus.frame_start = 1'b0;
        bus.sel_n       = '0;
        bus.data_in     = '0;
        bus.out_ready   = 1'b0;

        resetDut(3);

        ready_mode = 1;
        sendFrame(4'b1101);
        idle(3);

        ready_mode = 0;
        sendFrame(4'hA);
        sendFrame(4'h5);
        idle(3);
        ready_mode = 1;
        idle(4);

        sendBeat(1'b1, 2'd0, 1'b1);
        sendBeat(1'b0, 2'd2, 1'b0);
        idle(2);
        sendFrame(4'h3);
        idle(2);

        sendBeat(1'b1, 2'd0, 1'b1);
        sendBeat(1'b0, 2'd1, 1'b1);
        sendFrame(4'b0110);
        idle(2);

        sendBeat(1'b0, 2'd2, 1'b1);
        idle(2);

        sendBeat(1'b1, 2'd0, 1'b1);
        sendBeat(1'b0, 2'd1, 1'b0);
        resetDut(1);
        sendFrame(4'h9);
        idle(2);

        ready_mode = 2;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 10) begin
                idle(1);
            end else if (r < 18) begin
                sendBeat(1'($urandom_range(0, 1)), SEL_W'($urandom_range(0, LANES - 1)), LANE_W'($urandom));
            end else begin
                sendBeat(gen_idx == 0, SEL_W'(gen_idx), LANE_W'($urandom));
                gen_idx = (gen_idx + 1) % LANES;
            end
        end

        ready_mode = 1;
        idle(6);
        checkOutput("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/demux_1to4_deser.md
Name: demux_1to4_deser

Overview:
- Receiving end of the 4:1 select path. A serializer drives one lane symbol per beat, tagged with its lane index on sel_n, and this block routes each symbol into lane slot sel_n.
- Once all LANES slots of a frame are filled, it presents the reassembled parallel word with a valid/ready handshake.
- Sits between a serial/time-multiplexed link and parallel consumer logic.

Parameters:
- LANES, 4, number of lanes per frame (power of 2, >=2).
- LANE_W, 1, bits per lane symbol.
- SEL_W, $clog2(LANES), lane index width (derived, do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- data_in  input  LANE_W  lane symbol.
- sel_n  input  SEL_W  lane index of data_in.
- frame_start  input  1  marks first beat of a frame (must carry sel_n==0).
- in_valid  input  1  beat present.
- in_ready  output  1  beat accepted when in_valid&&in_ready.
- data_out  output  LANES*LANE_W  lane i at bits [i*LANE_W +: LANE_W].
- out_valid  output  1  data_out holds a complete frame.
- out_ready  input  1  consumer accepts; transfer on out_valid&&out_ready.
- err_seq  output  1  one-cycle pulse on protocol violation.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n low at a clk edge): state=IDLE, expected index exp=0, assembly register=0, data_out=0, out_valid=0, err_seq=0. in_ready=0 while rst_n is low.
- Reset mid-frame or mid-stall discards all partial and held data.
- Storage: assembly register asm (LANES*LANE_W) plus output register (data_out/out_valid).
- in_ready = (state != STALL) && rst_n, combinational.
- FSM states: IDLE, COLLECT, STALL.
- IDLE:
  - Accepted beat with frame_start=1 and sel_n=0: write asm lane 0, exp<=1, go COLLECT.
  - Any other accepted beat: dropped, err_seq pulses next cycle, stay IDLE.
- COLLECT:
  - Accepted beat with frame_start=0 and sel_n==exp: write asm lane exp, exp<=exp+1.
  - Accepted beat with frame_start=1 and sel_n=0: partial frame abandoned, err_seq pulse, asm lane 0 written, exp<=1, stay COLLECT (resync).
  - Any other accepted beat (wrong sel_n, or frame_start with sel_n!=0): partial frame discarded, err_seq pulse, go IDLE, exp<=0.
- Completion: accepted beat with sel_n==LANES-1 matching exp completes the frame.
  - If out_valid==0 or out_ready==1 in that cycle: data_out <= {new lane, asm other lanes} at that edge, out_valid<=1, go IDLE. Latency is 1 clk from the last accepted beat to out_valid.
  - Else: asm completed, go STALL.
- STALL: in_ready=0. When out_ready=1 (out_valid is 1), data_out<=asm, out_valid stays 1, go IDLE at that edge.
- Output handshake:
  - out_valid clears only on out_valid&&out_ready with no new frame loading the same edge.
  - data_out is stable while out_valid && !out_ready.
  - Back-to-back frames sustain 1 beat/clk when out_ready is held high.
- Single-beat frame is not possible (LANES>=2).
- Beats with in_valid=0 are ignored entirely; exp is held.
- err_seq is registered, asserted for exactly 1 cycle per violating beat.
- Data path has no arithmetic. exp wraps never occurs: frame completes at LANES-1.

Decomposition:
- Package demux_pkg holds:
  - state enum (IDLE, COLLECT, STALL), 2-bit encoding;
  - default constants LANES_DEF=4, LANE_W_DEF=1;
  - lane-slice helper function (index -> bit offset).
- One sub-module is natural: demux_out_reg, the output register with valid/ready hold logic (load, drain, stall). The top keeps the FSM, exp counter and asm register.

Test Plan:
- Reset: hold rst_n=0 for 3 clk with in_valid=1 -> data_out=0, out_valid=0, err_seq=0, in_ready=0; release -> in_ready=1.
- Nominal, LANES=4, LANE_W=1, out_ready=1: beats sel_n 0..3 with data 1,0,1,1, frame_start on beat 0 -> 1 clk after beat 3, data_out=4'b1101, out_valid=1 for 1 cycle, err_seq never set.
- Backpressure: out_ready=0 with frame A=4'hA held, then send full frame B=4'h5 -> in_ready drops after B's last beat (STALL), data_out stays 4'hA; raise out_ready -> next edge data_out=4'h5, out_valid=1, in_ready=1.
- Sequence error: frame_start,sel 0; then sel 2 -> err_seq one pulse, state IDLE, out_valid stays 0; subsequent clean frame 4'h3 -> data_out=4'h3.
- Resync: sel 0,1 then frame_start sel 0,1,2,3 with data 0,1,1,0 -> one err_seq pulse, data_out=4'b0110.
- Stray beat in IDLE: in_valid with sel_n=2, no frame_start -> dropped, err_seq pulse, no output. Mid-frame rst_n low for 1 clk -> partial frame discarded, next full frame reassembled correctly.
